// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the round-robin HC-SR04 ping scheduler.
package ultrasonic_pkg;
    localparam int CNT_W       = 24;
    localparam int IDX_W       = 3;
    localparam int MAX_SENSORS = 8;

    // Defaults assume a 64 MHz clock.
    localparam int DEF_TRIG_CYCLES    = 640;
    localparam int DEF_TIMEOUT_CYCLES = 2_560_000;
    localparam int DEF_GAP_CYCLES     = 3_840_000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        EMIT      = 3'd4,
        GAP       = 3'd5
    } state_t;
endpackage

// File: rtl/ultrasonic_echo_sync.sv
// Per-channel two-flop echo synchronizer with rise/fall detection on the synchronized level.
module ultrasonic_echo_sync #(
    parameter int NUM_SENSORS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] echo_rise,
    output logic [NUM_SENSORS-1:0] echo_fall
);
    logic [NUM_SENSORS-1:0] sync1_reg;
    logic [NUM_SENSORS-1:0] sync2_reg;
    logic [NUM_SENSORS-1:0] prev_reg;

    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_ch
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_reg[gi] <= 1'b0;
                sync2_reg[gi] <= 1'b0;
                prev_reg[gi]  <= 1'b0;
            end else begin
                sync1_reg[gi] <= echo[gi];
                sync2_reg[gi] <= sync1_reg[gi];
                prev_reg[gi]  <= sync2_reg[gi];
            end
        end

        assign echo_rise[gi] = sync2_reg[gi] & ~prev_reg[gi];
        assign echo_fall[gi] = ~sync2_reg[gi] & prev_reg[gi];
    end
endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 scheduler: trigger one sensor, time its echo, hand the result
// over a valid/ready port, then wait a quiet gap before moving to the next sensor.
module ultrasonic_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [IDX_W-1:0]       result_id,
    output logic [CNT_W-1:0]       result_cnt,
    output logic                   result_timeout,
    output logic                   busy
);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_SENSORS - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_inc;
    logic [IDX_W-1:0]       index_reg, index_next, index_wrap;
    logic [NUM_SENSORS-1:0] trigger_reg, trigger_next;
    logic [IDX_W-1:0]       res_id_reg, res_id_next;
    logic [CNT_W-1:0]       res_cnt_reg, res_cnt_next;
    logic                   res_to_reg, res_to_next;

    logic [NUM_SENSORS-1:0] echo_rise, echo_fall;
    logic [MAX_SENSORS-1:0] rise_pad, fall_pad;
    logic                   rise_sel, fall_sel;

    ultrasonic_echo_sync #(
        .NUM_SENSORS(NUM_SENSORS)
    ) u_echo_sync (
        .clk      (clk),
        .rst      (rst),
        .echo     (echo),
        .echo_rise(echo_rise),
        .echo_fall(echo_fall)
    );

    // Only the channel currently being pinged can influence the FSM.
    assign rise_pad   = MAX_SENSORS'(echo_rise);
    assign fall_pad   = MAX_SENSORS'(echo_fall);
    assign rise_sel   = rise_pad[index_reg];
    assign fall_sel   = fall_pad[index_reg];
    assign cnt_inc    = cnt_reg + CNT_W'(1);
    assign index_wrap = (index_reg == IDX_LAST) ? '0 : index_reg + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            index_reg   <= '0;
            trigger_reg <= '0;
            res_id_reg  <= '0;
            res_cnt_reg <= '0;
            res_to_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            index_reg   <= index_next;
            trigger_reg <= trigger_next;
            res_id_reg  <= res_id_next;
            res_cnt_reg <= res_cnt_next;
            res_to_reg  <= res_to_next;
        end
    end

    // MEASURE is entered one cycle after the rise, so the fall cycle itself still
    // counts as high time; this makes the reported width equal the echo width.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        index_next   = index_reg;
        res_id_next  = res_id_reg;
        res_cnt_next = res_cnt_reg;
        res_to_next  = res_to_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = TRIG;
                    cnt_next   = '0;
                end
            end
            TRIG: begin
                if (cnt_reg == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_RISE: begin
                if (rise_sel) begin
                    state_next = MEASURE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next   = EMIT;
                    cnt_next     = '0;
                    res_id_next  = index_reg;
                    res_cnt_next = '0;
                    res_to_next  = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            MEASURE: begin
                if (fall_sel) begin
                    state_next   = EMIT;
                    cnt_next     = '0;
                    res_id_next  = index_reg;
                    res_cnt_next = cnt_inc;
                    res_to_next  = 1'b0;
                end else if (cnt_inc == TIMEOUT_VAL) begin
                    state_next   = EMIT;
                    cnt_next     = '0;
                    res_id_next  = index_reg;
                    res_cnt_next = TIMEOUT_VAL;
                    res_to_next  = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            EMIT: begin
                if (result_ready) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    index_next = index_wrap;
                    state_next = enable ? TRIG : IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Trigger is registered from the next state so it is glitch-free and one-hot.
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_trig
        assign trigger_next[gi] = (state_next == TRIG) && (index_next == IDX_W'(gi));
    end

    always_comb begin
        result_valid   = (state_reg == EMIT);
        busy           = (state_reg != IDLE);
        trigger        = trigger_reg;
        result_id      = res_id_reg;
        result_cnt     = res_cnt_reg;
        result_timeout = res_to_reg;
    end
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler: stimulus pushes expected results, monitors pop and compare.
module tb_ultrasonic_scheduler;
    typedef struct packed {
        logic [2:0]  id;
        logic [23:0] cnt;
        logic        to;
    } res_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        result_ready;
    logic [3:0]  echo_in;
    logic [3:0]  trigger;
    logic        result_valid;
    logic [2:0]  result_id;
    logic [23:0] result_cnt;
    logic        result_timeout;
    logic        busy;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ultrasonic_scheduler #(
        .NUM_SENSORS   (4),
        .TRIG_CYCLES   (10),
        .TIMEOUT_CYCLES(1000),
        .GAP_CYCLES    (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .echo          (echo_in),
        .trigger       (trigger),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_id     (result_id),
        .result_cnt    (result_cnt),
        .result_timeout(result_timeout),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Result monitor: one line per transfer.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && result_valid && result_ready) begin
                check("sb_nonempty", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("result id=%0d cnt=%0d timeout=%0d (expected %0d/%0d/%0d)",
                             result_id, result_cnt, result_timeout, e.id, e.cnt, e.to);
                    check("result_id", result_id, e.id);
                    check("result_cnt", result_cnt, e.cnt);
                    check("result_timeout", result_timeout, e.to);
                end
            end
        end
    end

    // Trigger monitor: each completed pulse must be 10 cycles wide and one-hot.
    initial begin
        int run;
        bit multi;
        run = 0;
        multi = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
                multi = 0;
            end else if (trigger != 4'b0) begin
                run++;
                if ($countones(trigger) > 1) multi = 1;
            end else if (run > 0) begin
                $display("trigger pulse width=%0d", run);
                check("trig_width", run, 10);
                check("trig_onehot", multi, 0);
                run = 0;
                multi = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_trig(input int idx);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (trigger == 4'b0 && k < 5000);
        check("trig_select", trigger, longint'(1) << idx);
        k = 0;
        while (trigger != 4'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("trig_release", trigger, 0);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!result_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("valid_seen", result_valid, 1);
    endtask

    task automatic pulse_echo(input int idx, input int len);
        echo_in[idx] = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        echo_in[idx] = 1'b0;
    endtask

    initial begin
        int  k;
        bit  bad;
        rst          = 1'b1;
        enable       = 1'b0;
        result_ready = 1'b1;
        echo_in      = 4'b0;
        #1;
        check("rst_trigger", trigger, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_id", result_id, 0);
        check("rst_cnt", result_cnt, 0);
        check("rst_timeout", result_timeout, 0);
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b1;

        // Sensor 0: 300-cycle echo.
        wait_trig(0);
        exp_q.push_back('{id: 3'd0, cnt: 24'd300, to: 1'b0});
        pulse_echo(0, 300);

        // Sensor 1: no echo, timeout exactly 1000 cycles after trigger falls.
        wait_trig(1);
        exp_q.push_back('{id: 3'd1, cnt: 24'd0, to: 1'b1});
        k = 0;
        while (!result_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", k, 1000);

        // Sensor 2: echo stuck high, capped at the timeout.
        wait_trig(2);
        exp_q.push_back('{id: 3'd2, cnt: 24'd1000, to: 1'b1});
        echo_in[2] = 1'b1;
        wait_valid();
        echo_in[2] = 1'b0;

        // Sensor 3: short echo, then back-pressure on the wrapped sensor 0.
        wait_trig(3);
        exp_q.push_back('{id: 3'd3, cnt: 24'd5, to: 1'b0});
        pulse_echo(3, 5);
        wait_valid();
        @(posedge clk);
        #1;
        result_ready = 1'b0;

        wait_trig(0);
        exp_q.push_back('{id: 3'd0, cnt: 24'd20, to: 1'b0});
        pulse_echo(0, 20);
        wait_valid();
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!(result_valid && result_id == 3'd0 && result_cnt == 24'd20 &&
                  !result_timeout && trigger == 4'b0)) bad = 1;
        end
        check("stall_hold", bad, 0);
        check("stall_no_pop", exp_q.size(), 1);
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        @(posedge clk);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (trigger != 4'b0 || !busy) bad = 1;
        end
        check("gap_quiet", bad, 0);
        @(negedge clk);
        check("trig_after_gap", trigger, 4'b0010);

        // Reset in the middle of sensor 1's trigger pulse.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_trigger", trigger, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cnt", result_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Schedule restarts at sensor 0; enable drops mid-measure with noise elsewhere.
        wait_trig(0);
        exp_q.push_back('{id: 3'd0, cnt: 24'd100, to: 1'b0});
        echo_in[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 99) echo_in[0] = 1'b0;
            if (i == 40) enable = 1'b0;
            if (i % 3 == 0) echo_in[1] = ~echo_in[1];
            if (i % 5 == 0) echo_in[3] = ~echo_in[3];
        end
        echo_in[1] = 1'b0;
        echo_in[3] = 1'b0;
        k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", busy, 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || trigger != 4'b0) bad = 1;
        end
        check("idle_stays", bad, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ultrasonic_scheduler.md
ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, default 4, number of HC-SR04 channels serviced (2..8).
REQ-002 Parameter TRIG_CYCLES, default 640, trigger pulse width in clk cycles (10 us @ 64 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 2_560_000, echo wait/width limit (40 ms).
REQ-004 Parameter GAP_CYCLES, default 3_840_000, quiet time between pings (60 ms).
REQ-005 clk  input  1  system clock, 64 MHz, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; 1 = run round-robin ping schedule.
REQ-008 echo  input  NUM_SENSORS  raw asynchronous echo lines, bit i = sensor i.
REQ-009 trigger  output  NUM_SENSORS  trigger pulses, at most one bit high at any time.
REQ-010 result_valid  output  1  result fields valid.
REQ-011 result_ready  input  1  consumer accepts result.
REQ-012 result_id  output  3  sensor index of result.
REQ-013 result_cnt  output  24  echo high time in clk cycles.
REQ-014 result_timeout  output  1  1 = no echo or echo exceeded TIMEOUT_CYCLES.
REQ-015 busy  output  1  1 whenever FSM not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, EMIT, GAP.
REQ-017 IDLE: when enable=1, go to TRIG for current index; index starts at 0.
REQ-018 TRIG: trigger[index] SHALL be high for exactly TRIG_CYCLES cycles, registered output, then WAIT_RISE.
REQ-019 Each echo bit SHALL pass a 2-flop synchronizer; all decisions use synchronized echo (2-cycle latency).
REQ-020 WAIT_RISE: on synchronized rise of echo[index] go to MEASURE with count=0; if TIMEOUT_CYCLES cycles elapse first, go to EMIT with cnt=0, timeout=1.
REQ-021 MEASURE: count increments each cycle synchronized echo[index] is high; on its fall go to EMIT with cnt=count, timeout=0.
REQ-022 MEASURE: if count reaches TIMEOUT_CYCLES, go to EMIT with cnt=TIMEOUT_CYCLES, timeout=1; counter never wraps.
REQ-023 Echo activity on non-selected channels SHALL be ignored.
REQ-024 EMIT: result_valid=1; id/cnt/timeout SHALL stay stable until valid&&ready; transfer completes that cycle, then GAP.
REQ-025 Back-pressure: FSM SHALL stall in EMIT indefinitely while result_ready=0; no result dropped or overwritten.
REQ-026 GAP: wait GAP_CYCLES, index = (index+1) mod NUM_SENSORS; then TRIG if enable=1 else IDLE.
REQ-027 enable deasserted mid-ping SHALL not abort; current ping completes through EMIT and GAP, then IDLE.
REQ-028 result_valid may assert in the cycle ready is already high; 1-cycle transfer allowed.

Reset
REQ-029 On rst: state=IDLE, index=0, trigger=0, result_valid=0, result_id=0, result_cnt=0, result_timeout=0, busy=0, all counters and synchronizers 0, immediately and asynchronously.
REQ-030 Reset mid-trigger SHALL drop trigger same cycle; after release the schedule restarts at sensor 0.

Structure
REQ-031 Package ultrasonic_pkg SHALL hold the state enum, CNT_W=24, and default timing constants.
REQ-032 One sub-module, ultrasonic_echo_sync: per-channel 2-flop synchronizer plus rise/fall detect.
REQ-033 Single counter shared across TRIG, WAIT_RISE, MEASURE and GAP phases.

Verification (bench params TRIG=10, TIMEOUT=1000, GAP=50, N=4)
REQ-034 enable=1, echo[0] high 300 cycles after trigger fall -> trigger[0] high exactly 10 cycles; result id=0, cnt=300, timeout=0.
REQ-035 No echo on sensor 1 -> result id=1, cnt=0, timeout=1, 1000 cycles after trigger fall.
REQ-036 echo[2] held high forever -> id=2, cnt=1000, timeout=1; next ping goes to sensor 3 after GAP, then wraps to 0.
REQ-037 result_ready=0 for 500 cycles -> result fields stable, no trigger issued, transfer on ready, GAP follows.
REQ-038 rst pulse during TRIG of sensor 1 -> trigger all 0 asynchronously; after release first trigger on sensor 0.
REQ-039 enable dropped during MEASURE, echo on other channels toggling -> ping completes with correct cnt, FSM reaches IDLE, busy=0.
